// File: rtl/transaction_controller_pkg.sv
// Shared encodings for the transaction controller: FSM states, datapath step codes
// and default timing parameters.
package transaction_controller_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_LOAD_MEM   = 4'd1,
        ST_GET_PLAYER = 4'd2,
        ST_GET_AMOUNT = 4'd3,
        ST_GET_KEY    = 4'd4,
        ST_VERIFY_AMT = 4'd5,
        ST_VERIFY_KEY = 4'd6,
        ST_COMMIT     = 4'd7,
        ST_PASS       = 4'd8,
        ST_FAIL       = 4'd9
    } state_t;

    localparam logic [2:0] PROC_IDLE       = 3'b000;
    localparam logic [2:0] PROC_VERIFY_AMT = 3'b001;
    localparam logic [2:0] PROC_VERIFY_KEY = 3'b010;
    localparam logic [2:0] PROC_COMMIT     = 3'b011;

    localparam int DEFAULT_VERIFY_TIMEOUT  = 64;
    localparam int DEFAULT_MEM_LOAD_CYCLES = 2;

    // COMMIT is deliberately outside this range so a write is never torn.
    function automatic logic is_cancellable(input state_t s);
        return (s >= ST_LOAD_MEM) && (s <= ST_VERIFY_KEY);
    endfunction

    function automatic logic [2:0] proc_code(input state_t s);
        case (s)
            ST_VERIFY_AMT: return PROC_VERIFY_AMT;
            ST_VERIFY_KEY: return PROC_VERIFY_KEY;
            ST_COMMIT:     return PROC_COMMIT;
            default:       return PROC_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/transaction_controller_edge_detect.sv
// Rising-edge detector for the go request. History resets high so a button held
// through reset release does not fire.
module transaction_controller_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic sig,
    output logic sig_edge
);

    logic sig_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sig_prev <= 1'b1;
        end else begin
            sig_prev <= sig;
        end
    end

    assign sig_edge = sig & ~sig_prev;

endmodule

// File: rtl/transaction_controller.sv
// Transaction sequencer: load memory snapshot, collect player/amount/key, run the two
// datapath verify steps with timeout, then commit. All outputs registered.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | waiting for go
// LOAD_MEM    | load_memory held for MEM_LOAD_CYCLES, then auto-advance
// GET_PLAYER  | load_player high, go advances
// GET_AMOUNT  | load_amount high, go advances
// GET_KEY     | load_key high, go starts verification
// VERIFY_AMT  | process=001, wait done_step or timeout
// VERIFY_KEY  | process=010, wait done_step or timeout
// COMMIT      | process=011, single mem_write strobe
// PASS        | transaction succeeded, go returns to IDLE
// FAIL        | cancelled or timed out, go returns to IDLE
module transaction_controller
    import transaction_controller_pkg::*;
#(
    parameter int VERIFY_TIMEOUT  = DEFAULT_VERIFY_TIMEOUT,
    parameter int MEM_LOAD_CYCLES = DEFAULT_MEM_LOAD_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic       cancel,
    input  logic       done_step,
    output logic       load_memory,
    output logic       load_player,
    output logic       load_amount,
    output logic       load_key,
    output logic [2:0] process,
    output logic       mem_write,
    output logic       busy,
    output logic       pass,
    output logic       fail,
    output logic [3:0] state_out
);

    localparam logic [7:0] TO_LAST  = 8'(VERIFY_TIMEOUT - 1);
    localparam logic [7:0] MEM_LAST = 8'(MEM_LOAD_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       go_edge;

    transaction_controller_edge_detect u_edge_detect (
        .clock    (clock),
        .reset    (reset),
        .sig      (go),
        .sig_edge (go_edge)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (go_edge) begin
                    state_nxt = ST_LOAD_MEM;
                    cnt_nxt   = '0;
                end
            end
            ST_LOAD_MEM: begin
                if (cnt >= MEM_LAST) begin
                    state_nxt = ST_GET_PLAYER;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            ST_GET_PLAYER: if (go_edge) state_nxt = ST_GET_AMOUNT;
            ST_GET_AMOUNT: if (go_edge) state_nxt = ST_GET_KEY;
            ST_GET_KEY: begin
                if (go_edge) begin
                    state_nxt = ST_VERIFY_AMT;
                    cnt_nxt   = '0;
                end
            end
            ST_VERIFY_AMT, ST_VERIFY_KEY: begin
                // done_step lags the step code by a cycle, so cnt==0 is blind
                if ((cnt != 8'd0) && done_step) begin
                    if (state == ST_VERIFY_AMT) state_nxt = ST_VERIFY_KEY;
                    else                        state_nxt = ST_COMMIT;
                    cnt_nxt = '0;
                end else if (cnt >= TO_LAST) begin
                    state_nxt = ST_FAIL;
                    cnt_nxt   = '0;
                end else if (cnt != 8'hFF) begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            ST_COMMIT: state_nxt = ST_PASS;
            ST_PASS, ST_FAIL: if (go_edge) state_nxt = ST_IDLE;
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        if (cancel && is_cancellable(state)) begin
            state_nxt = ST_FAIL;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            load_memory <= 1'b0;
            load_player <= 1'b0;
            load_amount <= 1'b0;
            load_key    <= 1'b0;
            process     <= PROC_IDLE;
            mem_write   <= 1'b0;
            busy        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            state_out   <= 4'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            load_memory <= (state_nxt == ST_LOAD_MEM);
            load_player <= (state_nxt == ST_GET_PLAYER);
            load_amount <= (state_nxt == ST_GET_AMOUNT);
            load_key    <= (state_nxt == ST_GET_KEY);
            process     <= proc_code(state_nxt);
            mem_write   <= (state_nxt == ST_COMMIT);
            busy        <= !(state_nxt inside {ST_IDLE, ST_PASS, ST_FAIL});
            pass        <= (state_nxt == ST_PASS);
            fail        <= (state_nxt == ST_FAIL);
            state_out   <= state_nxt;
        end
    end

endmodule
